chip8_alu_sequencer: RTL
========================

Name: chip8_alu_sequencer

Overview:
Multi-cycle controller that executes CHIP-8 8XYN register-arithmetic instructions. It reads Vx and Vy from the register file, drives Chip8_ALU with the decoded ALU_f operation, then writes the result to Vx and the flag to VF. It sits between the CPU decode stage and the shared ALU/register file, using a start/done handshake toward the CPU.

Parameters:
DATA_W, 8, register width; operands are zero-extended to 16 bits for the ALU.
RADDR_W, 4, register file address width (V0..VF).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
instr  in  16  8XYN opcode; captured when start is accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
illegal  out  1  pulses together with done when N is unsupported
rf_raddr  out  4  register file read address (synchronous read, 1-cycle latency)
rf_rdata  in  8  register file read data
rf_we  out  1  register file write enable
rf_waddr  out  4  register file write address
rf_wdata  out  8  register file write data
alu_input1  out  16  to ALU input1
alu_input2  out  16  to ALU input2
alu_sel  out  ALU_f  to ALU sel
alu_out  in  16  ALU result
alu_carry  in  1  ALU carry/borrow

Behaviour:
- Reset: state=IDLE. busy, done, illegal, rf_we = 0. rf_raddr, rf_waddr, rf_wdata = 0. alu_input1/2 = 0. alu_sel = ALU_f_NOP.
- States: IDLE, RD_X, RD_Y, RD_WAIT, EXEC, WB_X, WB_F, DONE.
- IDLE: if start is high, latch instr.
  - Legal N: go to RD_X.
  - Illegal N: go to DONE with illegal set; no read or write is performed.
  - start while busy is ignored.
- RD_X: rf_raddr = X.
- RD_Y: rf_raddr = Y; latch rf_rdata as opx at the end of the cycle.
- RD_WAIT: latch rf_rdata as opy.
- EXEC:
  - Drive alu_sel and the operands; alu_sel is ALU_f_NOP in every other state.
  - Latch alu_out[7:0] as res and the flag source as flg.
- WB_X: rf_we=1, rf_waddr=X, rf_wdata=res.
- WB_F: rf_we=1, rf_waddr=4'hF, rf_wdata={7'b0,flg}.
  - Entered only for flag-writing ops; all other ops go WB_X→DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: done is asserted in the 7th cycle after the start edge for flag ops, the 6th for non-flag ops, and the 1st for illegal N.
- Decode (input1, input2, sel, flag):
  - N=0: Vy, 0, OR; no flag.
  - N=1: Vx, Vy, OR; no flag.
  - N=2: Vx, Vy, AND; no flag.
  - N=3: Vx, Vy, XOR; no flag.
  - N=4: Vx, Vy, ADD; flag = carry out of bit 7 (alu_out[8]).
  - N=5: Vx, Vy, MINUS; flag = (Vx>=Vy).
  - N=6: Vx, 1, RSHIFT; flag = Vx[0].
  - N=7: Vy, Vx, MINUS; flag = (Vy>=Vx).
  - N=E: Vx, 1, LSHIFT; flag = Vx[7].
  - N=8..D and N=F are illegal.
- Flag writes: the flag is computed locally from the latched operands, never from alu_carry.
- Width: results are truncated to 8 bits. Wrap-around is required (0xFF+0x01 gives 0x00 with VF=1).
- X==F or Y==F: operands are read before any write. The VF write follows the Vx write, so the flag wins.
- X==Y is legal; both reads return the same register.
- Reset mid-operation: immediate return to IDLE with rf_we low. Completed writes are not rolled back.

Optional Feature:
CHIP8_ALU_VF_RESET_EN
- Defined: N=1/2/3 also pass through WB_F, writing VF=0x00 (COSMAC quirk); their latency becomes 7 cycles.
- Undefined: logic ops leave VF untouched.

Decomposition:
- Shared package enums.svh gains:
  - the sequencer state enum;
  - ALU8_N_* nibble constants;
  - the flag-source enum FLAG_NONE / FLAG_CARRY / FLAG_GE / FLAG_LSB / FLAG_MSB / FLAG_ZERO.
- One combinational sub-module, chip8_alu_decode.
  - Input: N.
  - Outputs: ALU_f, operand-swap, use-Vy-only, shift-by-1, flag source, valid.
- The sequencer holds only the FSM and datapath registers.

Test Plan:
- V1=0xB4, V2=0xB4, instr 8124 → V1=0x68, then VF=0x01; done in cycle 7; exactly two rf_we pulses (addr 1, then F).
- V1=0x05, V2=0x07, instr 8125 → V1=0xFE, VF=0x00. Then instr 8127 with the same operands → V1=0x02, VF=0x01.
- V1=0x31, instr 8106 → V1=0x18, VF=0x01. V1=0x81, instr 810E → V1=0x02, VF=0x01.
- VF=0xFF, V1=0x01, instr 8F14 → writes VF=0x00, then VF=0x01; final VF=0x01.
- instr 8128 → done and illegal high in cycle 1, rf_we never asserted. start pulsed while busy → ignored.
- reset asserted during EXEC of 8124 → busy=0, alu_sel=NOP, rf_we=0 immediately, V1 unchanged. A following 8121 with V1=0xF0, V2=0x0F → V1=0xFF, done in cycle 6 (cycle 7 and VF=0x00 with CHIP8_ALU_VF_RESET_EN).

Source files
------------

// File: rtl/chip8_alu_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip8_alu_sequencer_pkg : ALU op, sequencer state and flag-source types     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package chip8_alu_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_f_NOP    = 4'd0,
        ALU_f_OR     = 4'd1,
        ALU_f_AND    = 4'd2,
        ALU_f_XOR    = 4'd3,
        ALU_f_ADD    = 4'd4,
        ALU_f_MINUS  = 4'd5,
        ALU_f_RSHIFT = 4'd6,
        ALU_f_LSHIFT = 4'd7
    } ALU_f;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_X    = 3'd1,
        S_RD_Y    = 3'd2,
        S_RD_WAIT = 3'd3,
        S_EXEC    = 3'd4,
        S_WB_X    = 3'd5,
        S_WB_F    = 3'd6,
        S_DONE    = 3'd7
    } seq_state_t;

    typedef enum logic [2:0] {
        FLAG_NONE  = 3'd0,
        FLAG_CARRY = 3'd1,
        FLAG_GE    = 3'd2,
        FLAG_LSB   = 3'd3,
        FLAG_MSB   = 3'd4,
        FLAG_ZERO  = 3'd5
    } flag_src_t;

    localparam logic [3:0] ALU8_N_LD   = 4'h0;
    localparam logic [3:0] ALU8_N_OR   = 4'h1;
    localparam logic [3:0] ALU8_N_AND  = 4'h2;
    localparam logic [3:0] ALU8_N_XOR  = 4'h3;
    localparam logic [3:0] ALU8_N_ADD  = 4'h4;
    localparam logic [3:0] ALU8_N_SUB  = 4'h5;
    localparam logic [3:0] ALU8_N_SHR  = 4'h6;
    localparam logic [3:0] ALU8_N_SUBN = 4'h7;
    localparam logic [3:0] ALU8_N_SHL  = 4'hE;

endpackage
`default_nettype wire

// File: rtl/chip8_alu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip8_alu_decode : 8XYN nibble to ALU op / operand routing / flag source    |
// | Option: CHIP8_ALU_VF_RESET_EN makes N=1/2/3 clear VF. Rev 1.0              |
// +----------------------------------------------------------------------------+
module chip8_alu_decode
    import chip8_alu_sequencer_pkg::*;
(
    input  logic [3:0] i_n,
    output ALU_f       o_sel,
    output logic       o_swap,
    output logic       o_vy_only,
    output logic       o_shift1,
    output flag_src_t  o_flag,
    output logic       o_valid
);

`ifdef CHIP8_ALU_VF_RESET_EN
    localparam flag_src_t c_LOGIC_FLAG = FLAG_ZERO;
`else
    localparam flag_src_t c_LOGIC_FLAG = FLAG_NONE;
`endif

    always_comb begin
        o_sel     = ALU_f_NOP;
        o_swap    = 1'b0;
        o_vy_only = 1'b0;
        o_shift1  = 1'b0;
        o_flag    = FLAG_NONE;
        o_valid   = 1'b1;
        case (i_n)
            ALU8_N_LD:   begin o_sel = ALU_f_OR;     o_vy_only = 1'b1; end
            ALU8_N_OR:   begin o_sel = ALU_f_OR;     o_flag = c_LOGIC_FLAG; end
            ALU8_N_AND:  begin o_sel = ALU_f_AND;    o_flag = c_LOGIC_FLAG; end
            ALU8_N_XOR:  begin o_sel = ALU_f_XOR;    o_flag = c_LOGIC_FLAG; end
            ALU8_N_ADD:  begin o_sel = ALU_f_ADD;    o_flag = FLAG_CARRY; end
            ALU8_N_SUB:  begin o_sel = ALU_f_MINUS;  o_flag = FLAG_GE; end
            ALU8_N_SHR:  begin o_sel = ALU_f_RSHIFT; o_shift1 = 1'b1; o_flag = FLAG_LSB; end
            ALU8_N_SUBN: begin o_sel = ALU_f_MINUS;  o_swap = 1'b1; o_flag = FLAG_GE; end
            ALU8_N_SHL:  begin o_sel = ALU_f_LSHIFT; o_shift1 = 1'b1; o_flag = FLAG_MSB; end
            default:     o_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/chip8_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip8_alu_sequencer : multi-cycle 8XYN executor (read Vx/Vy, ALU, write)   |
// | Option: CHIP8_ALU_VF_RESET_EN (handled in chip8_alu_decode). Rev 1.0       |
// +----------------------------------------------------------------------------+
module chip8_alu_sequencer
    import chip8_alu_sequencer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [15:0]        i_instr,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_illegal,
    output logic [RADDR_W-1:0] o_rf_raddr,
    input  logic [DATA_W-1:0]  i_rf_rdata,
    output logic               o_rf_we,
    output logic [RADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0]  o_rf_wdata,
    output logic [15:0]        o_alu_input1,
    output logic [15:0]        o_alu_input2,
    output ALU_f               o_alu_sel,
    input  logic [15:0]        i_alu_out,
    input  logic               i_alu_carry
);

    localparam int c_ALU_W = 16;

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [RADDR_W-1:0]  r_x;
    logic [RADDR_W-1:0]  r_y;
    logic [3:0]          r_n;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_opx;
    logic [DATA_W-1:0]   r_opy;
    logic [DATA_W-1:0]   r_res;
    logic                r_flg;

    logic [3:0]          w_dec_n;
    ALU_f                w_dec_sel;
    logic                w_dec_swap;
    logic                w_dec_vy_only;
    logic                w_dec_shift1;
    flag_src_t           w_dec_flag;
    logic                w_dec_valid;
    logic [DATA_W-1:0]   w_in1;
    logic [DATA_W-1:0]   w_in2;
    logic [DATA_W:0]     w_sum;
    logic                w_flag;
    logic                w_unused;

    // In IDLE the incoming opcode is decoded to decide legality; afterwards the latched N.
    assign w_dec_n = (r_state == S_IDLE) ? i_instr[3:0] : r_n;

    chip8_alu_decode u_decode (
        .i_n       (w_dec_n),
        .o_sel     (w_dec_sel),
        .o_swap    (w_dec_swap),
        .o_vy_only (w_dec_vy_only),
        .o_shift1  (w_dec_shift1),
        .o_flag    (w_dec_flag),
        .o_valid   (w_dec_valid)
    );

    always_comb begin
        w_in1 = r_opx;
        w_in2 = r_opy;
        if (w_dec_vy_only) begin
            w_in1 = r_opy;
            w_in2 = '0;
        end else if (w_dec_shift1) begin
            w_in2 = {{(DATA_W-1){1'b0}}, 1'b1};
        end else if (w_dec_swap) begin
            w_in1 = r_opy;
            w_in2 = r_opx;
        end
    end

    // VF is derived from the latched operands so it never depends on ALU carry semantics.
    assign w_sum = {1'b0, r_opx} + {1'b0, r_opy};

    always_comb begin
        w_flag = 1'b0;
        case (w_dec_flag)
            FLAG_CARRY: w_flag = w_sum[DATA_W];
            FLAG_GE:    w_flag = (w_in1 >= w_in2);
            FLAG_LSB:   w_flag = r_opx[0];
            FLAG_MSB:   w_flag = r_opx[DATA_W-1];
            default:    w_flag = 1'b0;
        endcase
    end

    assign w_unused = ^{i_alu_carry, i_alu_out[c_ALU_W-1:DATA_W], i_instr[15:12], w_sum[DATA_W-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = w_dec_valid ? S_RD_X : S_DONE;
            S_RD_X:    w_next = S_RD_Y;
            S_RD_Y:    w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_EXEC;
            S_EXEC:    w_next = S_WB_X;
            S_WB_X:    w_next = (w_dec_flag != FLAG_NONE) ? S_WB_F : S_DONE;
            S_WB_F:    w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_n       <= '0;
            r_illegal <= 1'b0;
            r_opx     <= '0;
            r_opy     <= '0;
            r_res     <= '0;
            r_flg     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_x       <= i_instr[8 +: RADDR_W];
                r_y       <= i_instr[4 +: RADDR_W];
                r_n       <= i_instr[3:0];
                r_illegal <= ~w_dec_valid;
            end
            if (r_state == S_RD_Y) r_opx <= i_rf_rdata;
            if (r_state == S_RD_WAIT) r_opy <= i_rf_rdata;
            if (r_state == S_EXEC) begin
                r_res <= i_alu_out[DATA_W-1:0];
                r_flg <= w_flag;
            end
        end
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_done       = 1'b0;
        o_illegal    = 1'b0;
        o_rf_raddr   = '0;
        o_rf_we      = 1'b0;
        o_rf_waddr   = '0;
        o_rf_wdata   = '0;
        o_alu_input1 = '0;
        o_alu_input2 = '0;
        o_alu_sel    = ALU_f_NOP;
        case (r_state)
            S_RD_X: o_rf_raddr = r_x;
            S_RD_Y: o_rf_raddr = r_y;
            S_EXEC: begin
                o_alu_sel    = w_dec_sel;
                o_alu_input1 = {{(c_ALU_W-DATA_W){1'b0}}, w_in1};
                o_alu_input2 = {{(c_ALU_W-DATA_W){1'b0}}, w_in2};
            end
            S_WB_X: begin
                o_rf_we    = 1'b1;
                o_rf_waddr = r_x;
                o_rf_wdata = r_res;
            end
            S_WB_F: begin
                o_rf_we    = 1'b1;
                o_rf_waddr = {RADDR_W{1'b1}};
                o_rf_wdata = {{(DATA_W-1){1'b0}}, r_flg};
            end
            S_DONE: begin
                o_done    = 1'b1;
                o_illegal = r_illegal;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
